// File: rtl/dense_layer_sequencer.sv
// Walks a descriptor table in SDRAM and programs denseController layer by layer.
// Define DLS_IRQ_EN to add the sticky completion interrupt port 'irq'.
module dense_layer_sequencer #(
    parameter int unsigned DESC_STRIDE = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic [2:0]  dc_address,
    output logic        dc_write,
    output logic [31:0] dc_writedata,
    input  logic        dc_waitrequest
`ifdef DLS_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned DW         = 32;
    localparam int unsigned DESC_WORDS = 5;
    localparam int unsigned K_W        = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PROG,
        S_KICK,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    layer_addr_q, layer_addr_d;
    logic [DW-1:0]    desc_q [DESC_WORDS];
    logic [DW-1:0]    desc_d [DESC_WORDS];
    logic [DW-1:0]    table_base_q, table_base_d;
    logic [CNT_W-1:0] layer_count_q, layer_count_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic busy;
    logic wr_ctrl;
    logic start_req;
    logic start_ok;
    logic last_word;
    logic last_layer;

    assign busy       = (state_q != S_IDLE);
    assign wr_ctrl    = slave_write && (slave_address == 3'd0);
    assign start_req  = wr_ctrl && slave_writedata[0];
    assign start_ok   = start_req && !busy;
    assign last_word  = (k_q == K_W'(DESC_WORDS - 1));
    assign last_layer = ((idx_q + CNT_W'(1)) == layer_count_q);

    assign slave_waitrequest = 1'b0;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (layer_count_q == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (!mem_waitrequest && last_word) begin
                    state_d = S_PROG;
                end
            end
            S_PROG: begin
                if (!dc_waitrequest && last_word) begin
                    state_d = S_KICK;
                end
            end
            S_KICK: begin
                if (!dc_waitrequest) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT:  state_d = last_layer ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Master-port outputs decoded from state; only one master is ever active
    always_comb begin
        mem_read     = 1'b0;
        mem_address  = '0;
        dc_write     = 1'b0;
        dc_address   = '0;
        dc_writedata = '0;
        case (state_q)
            S_FETCH: begin
                mem_read    = 1'b1;
                mem_address = layer_addr_q + DW'(k_q);
            end
            S_PROG: begin
                dc_write     = 1'b1;
                dc_address   = k_q + 3'd1;
                dc_writedata = desc_q[k_q];
            end
            S_KICK: begin
                dc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Word counter, layer index, running descriptor address and fetched words
    always_comb begin
        k_d          = k_q;
        idx_d        = idx_q;
        layer_addr_d = layer_addr_q;
        desc_d       = desc_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok && (layer_count_q != '0)) begin
                    k_d          = '0;
                    idx_d        = '0;
                    layer_addr_d = table_base_q;
                end
            end
            S_FETCH: begin
                if (!mem_waitrequest) begin
                    desc_d[k_q] = mem_readdata;
                    k_d         = last_word ? '0 : k_q + K_W'(1);
                end
            end
            S_PROG: begin
                if (!dc_waitrequest) begin
                    k_d = last_word ? '0 : k_q + K_W'(1);
                end
            end
            S_NEXT: begin
                if (!last_layer) begin
                    idx_d        = idx_q + CNT_W'(1);
                    layer_addr_d = layer_addr_q + DW'(DESC_STRIDE);
                end
            end
            default: ;
        endcase
    end

    // CSR updates; configuration writes and starts are refused while a run is active
    always_comb begin
        table_base_d  = table_base_q;
        layer_count_d = layer_count_q;
        done_d        = done_q;
        err_d         = err_q;
        if (slave_write) begin
            case (slave_address)
                3'd0: begin
                    if (slave_writedata[0]) begin
                        if (busy) begin
                            err_d = 1'b1;
                        end else begin
                            done_d = 1'b0;
                            err_d  = 1'b0;
                        end
                    end
                end
                3'd1: begin
                    if (busy) begin
                        err_d = 1'b1;
                    end else begin
                        table_base_d = slave_writedata;
                    end
                end
                3'd2: begin
                    if (busy) begin
                        err_d = 1'b1;
                    end else begin
                        layer_count_d = slave_writedata[CNT_W-1:0];
                    end
                end
                default: ;
            endcase
        end
        if (state_q == S_DONE) begin
            done_d = 1'b1;
        end
    end

    // Zero-latency CSR read mux
    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                3'd0:    slave_readdata = {29'b0, err_q, done_q, busy};
                3'd1:    slave_readdata = table_base_q;
                3'd2:    slave_readdata = DW'(layer_count_q);
                3'd3:    slave_readdata = DW'(idx_q);
                default: slave_readdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q           <= '0;
            idx_q         <= '0;
            layer_addr_q  <= '0;
            table_base_q  <= '0;
            layer_count_q <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            for (int i = 0; i < int'(DESC_WORDS); i++) begin
                desc_q[i] <= '0;
            end
        end else begin
            k_q           <= k_d;
            idx_q         <= idx_d;
            layer_addr_q  <= layer_addr_d;
            table_base_q  <= table_base_d;
            layer_count_q <= layer_count_d;
            done_q        <= done_d;
            err_q         <= err_d;
            desc_q        <= desc_d;
        end
    end

`ifdef DLS_IRQ_EN
    logic irq_q, irq_d;

    // Sticky interrupt: raised on entry to DONE, cleared by CTRL bit1 or an accepted start
    always_comb begin
        irq_d = irq_q;
        if (wr_ctrl && (slave_writedata[1] || start_ok)) begin
            irq_d = 1'b0;
        end
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Self-checking bench for dense_layer_sequencer: CSR vector table, directed runs and
// randomized runs compared against a table-walk model of the expected bus traffic.
`timescale 1ns/1ps
module tb_dense_layer_sequencer;

    localparam int unsigned DESC_STRIDE = 8;
    localparam int unsigned CNT_W       = 8;

    logic        clk;
    logic        reset;
    logic [2:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic [2:0]  dc_address;
    logic        dc_write;
    logic [31:0] dc_writedata;
    logic        dc_waitrequest;
`ifdef DLS_IRQ_EN
    logic        irq;
`endif

    int vecs = 0;
    int errs = 0;

    int mem_stall_cfg  = 0;
    int kick_stall_cfg = 0;
    int mem_cnt;
    int dc_cnt;

    logic [31:0] mem_q [$];
    logic [34:0] dc_q  [$];
    int          mem_stab_viol = 0;
    int          dc_stab_viol  = 0;
    int          excl_viol     = 0;
    logic        prev_mem_wait;
    logic        prev_dc_wait;
    logic [31:0] prev_mem_addr;
    logic [34:0] prev_dc;

    int mem_base_idx;
    int dc_base_idx;
    int viol_base;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;
    } csr_vec_t;

    csr_vec_t csr_tbl [14];

    dense_layer_sequencer #(
        .DESC_STRIDE(DESC_STRIDE),
        .CNT_W      (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .slave_address    (slave_address),
        .slave_read       (slave_read),
        .slave_readdata   (slave_readdata),
        .slave_write      (slave_write),
        .slave_writedata  (slave_writedata),
        .slave_waitrequest(slave_waitrequest),
        .mem_address      (mem_address),
        .mem_read         (mem_read),
        .mem_readdata     (mem_readdata),
        .mem_waitrequest  (mem_waitrequest),
        .dc_address       (dc_address),
        .dc_write         (dc_write),
        .dc_writedata     (dc_writedata),
        .dc_waitrequest   (dc_waitrequest)
`ifdef DLS_IRQ_EN
        ,
        .irq              (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SDRAM contents: the two test-plan descriptors plus a hash everywhere else
    function automatic logic [31:0] memval(input logic [31:0] a);
        case (a)
            32'd64:  return 32'd15;
            32'd65:  return 32'd1;
            32'd66:  return 32'd10;
            32'd67:  return 32'd32;
            32'd68:  return 32'd3;
            32'd72:  return 32'd15;
            32'd73:  return 32'd100;
            32'd74:  return 32'd32;
            32'd75:  return 32'd200;
            32'd76:  return 32'd3;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    assign mem_readdata    = memval(mem_address);
    assign mem_waitrequest = mem_read && (mem_cnt < mem_stall_cfg);
    assign dc_waitrequest  = dc_write && (dc_address == 3'd0) && (dc_cnt < kick_stall_cfg);

    // Stall counters: each transfer is held for the configured number of cycles
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_cnt <= 0;
            dc_cnt  <= 0;
        end else begin
            mem_cnt <= (mem_read && mem_waitrequest) ? mem_cnt + 1 : 0;
            dc_cnt  <= (dc_write && dc_waitrequest) ? dc_cnt + 1 : 0;
        end
    end

    // Bus monitor: logs completed transfers and protocol violations
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            prev_mem_wait <= 1'b0;
            prev_dc_wait  <= 1'b0;
            prev_mem_addr <= '0;
            prev_dc       <= '0;
        end else begin
            if (prev_mem_wait && (!mem_read || (mem_address != prev_mem_addr)))
                mem_stab_viol <= mem_stab_viol + 1;
            if (prev_dc_wait && (!dc_write || ({dc_address, dc_writedata} != prev_dc)))
                dc_stab_viol <= dc_stab_viol + 1;
            if (mem_read && dc_write)
                excl_viol <= excl_viol + 1;
            if (mem_read && !mem_waitrequest)
                mem_q.push_back(mem_address);
            if (dc_write && !dc_waitrequest)
                dc_q.push_back({dc_address, dc_writedata});
            prev_mem_wait <= mem_read && mem_waitrequest;
            prev_dc_wait  <= dc_write && dc_waitrequest;
            prev_mem_addr <= mem_address;
            prev_dc       <= {dc_address, dc_writedata};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        @(posedge clk);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        slave_address = a;
        slave_read    = 1'b1;
        #1;
        d = slave_readdata;
        @(posedge clk);
        #1;
        slave_read = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] base, input int cnt, input int ms, input int kd);
        mem_stall_cfg  = ms;
        kick_stall_cfg = kd;
        mem_base_idx   = mem_q.size();
        dc_base_idx    = dc_q.size();
        viol_base      = mem_stab_viol + dc_stab_viol + excl_viol;
        csr_wr(3'd1, base);
        csr_wr(3'd2, 32'(cnt));
        csr_wr(3'd0, 32'd1);
    endtask

    // Polls STATUS until idle, then checks traffic against a walk of the descriptor table
    task automatic finish_run(input string tag, input logic [31:0] base, input int cnt,
                              input int ms, input int kd, input bit chk_cyc,
                              input logic [31:0] exp_status);
        logic [31:0] s;
        logic [31:0] a;
        int          cyc;
        bit          idle_seen;
        logic [31:0] exp_mem [$];
        logic [34:0] exp_dc  [$];
        cyc       = 0;
        idle_seen = 1'b0;
        s         = '0;
        for (int i = 0; i < 4000; i++) begin
            csr_rd(3'd0, s);
            if (!s[0]) begin
                idle_seen = 1'b1;
                break;
            end
            cyc++;
        end
        chk({tag, " idle_reached"}, 64'(idle_seen), 64'd1);
        chk({tag, " status"}, 64'(s), 64'(exp_status));
        if (chk_cyc)
            chk({tag, " busy_cycles"}, 64'(cyc),
                64'((cnt == 0) ? 1 : cnt * (5 * (ms + 1) + 5 + 1 + kd + 1) + 1));
        for (int l = 0; l < cnt; l++) begin
            for (int k = 0; k < 5; k++) begin
                a = base + 32'(l) * 32'(DESC_STRIDE) + 32'(k);
                exp_mem.push_back(a);
                exp_dc.push_back({3'(k + 1), memval(a)});
            end
            exp_dc.push_back(35'd0);
        end
        chk({tag, " mem_read_count"}, 64'(mem_q.size() - mem_base_idx), 64'(exp_mem.size()));
        for (int i = 0; i < exp_mem.size(); i++)
            if (mem_base_idx + i < mem_q.size())
                chk({tag, " mem_address"}, 64'(mem_q[mem_base_idx + i]), 64'(exp_mem[i]));
        chk({tag, " dc_write_count"}, 64'(dc_q.size() - dc_base_idx), 64'(exp_dc.size()));
        for (int i = 0; i < exp_dc.size(); i++)
            if (dc_base_idx + i < dc_q.size())
                chk({tag, " dc_addr_data"}, 64'(dc_q[dc_base_idx + i]), 64'(exp_dc[i]));
        chk({tag, " protocol_violations"},
            64'(mem_stab_viol + dc_stab_viol + excl_viol - viol_base), 64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rbase;
        bit          found;
        int          rcnt, rms, rkd;

        reset           = 1'b0;
        slave_address   = '0;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_writedata = '0;

        csr_tbl = '{
            '{1'b0, 3'd0, 32'h0},
            '{1'b0, 3'd1, 32'h0},
            '{1'b0, 3'd2, 32'h0},
            '{1'b0, 3'd3, 32'h0},
            '{1'b1, 3'd1, 32'hDEAD_BEEF},
            '{1'b0, 3'd1, 32'hDEAD_BEEF},
            '{1'b1, 3'd2, 32'h0000_01FF},
            '{1'b0, 3'd2, 32'h0000_00FF},
            '{1'b1, 3'd5, 32'h0000_0123},
            '{1'b0, 3'd5, 32'h0},
            '{1'b1, 3'd3, 32'h0000_0055},
            '{1'b0, 3'd3, 32'h0},
            '{1'b0, 3'd7, 32'h0},
            '{1'b0, 3'd0, 32'h0}
        };

        repeat (3) @(posedge clk);
        #1;
        chk("reset mem_read", 64'(mem_read), 64'd0);
        chk("reset dc_write", 64'(dc_write), 64'd0);
        chk("reset dc_address", 64'(dc_address), 64'd0);
        chk("reset mem_address", 64'(mem_address), 64'd0);
        chk("reset waitrequest", 64'(slave_waitrequest), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            if (csr_tbl[i].wr) begin
                csr_wr(csr_tbl[i].addr, csr_tbl[i].data);
            end else begin
                csr_rd(csr_tbl[i].addr, rd);
                chk($sformatf("csr_tbl[%0d] addr %0d", i, csr_tbl[i].addr), 64'(rd),
                    64'(csr_tbl[i].data));
            end
        end

        start_run(32'd64, 1, 0, 20);
        finish_run("one_layer", 32'd64, 1, 0, 20, 1'b1, 32'h2);

        start_run(32'd64, 2, 0, 10);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (dc_write && (dc_address == 3'd0) && (dc_q.size() - dc_base_idx >= 6)) begin
                found = 1'b1;
                break;
            end
        end
        chk("two_layer kick2_reached", 64'(found), 64'd1);
        csr_rd(3'd3, rd);
        chk("two_layer cur_layer_in_kick2", 64'(rd), 64'd1);
        csr_rd(3'd0, rd);
        chk("two_layer done_before_finish", 64'(rd[1]), 64'd0);
        finish_run("two_layer", 32'd64, 2, 0, 10, 1'b0, 32'h2);

        start_run(32'd64, 0, 0, 0);
        finish_run("zero_layers", 32'd64, 0, 0, 0, 1'b1, 32'h2);

        start_run(32'd64, 2, 0, 5);
        repeat (4) @(posedge clk);
        #1;
        csr_wr(3'd0, 32'd1);
        csr_wr(3'd1, 32'd999);
        csr_wr(3'd2, 32'd7);
        finish_run("busy_start", 32'd64, 2, 0, 5, 1'b0, 32'h6);
        csr_rd(3'd1, rd);
        chk("busy_start table_base_kept", 64'(rd), 64'd64);
        csr_rd(3'd2, rd);
        chk("busy_start layer_count_kept", 64'(rd), 64'd2);
        start_run(32'd64, 0, 0, 0);
        finish_run("restart_clears_err", 32'd64, 0, 0, 0, 1'b1, 32'h2);

        start_run(32'd64, 1, 3, 2);
        finish_run("mem_stall", 32'd64, 1, 3, 2, 1'b1, 32'h2);

        start_run(32'd64, 1, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (dc_write && (dc_address == 3'd2)) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_reset prog_reached", 64'(found), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_reset dc_write", 64'(dc_write), 64'd0);
        chk("mid_reset mem_read", 64'(mem_read), 64'd0);
        slave_address = 3'd0;
        slave_read    = 1'b1;
        #1;
        chk("mid_reset status", 64'(slave_readdata), 64'd0);
        slave_address = 3'd1;
        #1;
        chk("mid_reset table_base", 64'(slave_readdata), 64'd0);
        slave_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start_run(32'd64, 1, 0, 4);
        finish_run("after_reset", 32'd64, 1, 0, 4, 1'b1, 32'h2);

        start_run(32'hFFFF_FFFA, 2, 1, 3);
        finish_run("addr_wrap", 32'hFFFF_FFFA, 2, 1, 3, 1'b1, 32'h2);

        for (int r = 0; r < 6; r++) begin
            rbase = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : 32'($urandom);
            rcnt  = int'($urandom_range(1, 4));
            rms   = int'($urandom_range(0, 2));
            rkd   = int'($urandom_range(0, 6));
            start_run(rbase, rcnt, rms, rkd);
            finish_run($sformatf("random[%0d]", r), rbase, rcnt, rms, rkd, 1'b1, 32'h2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
